// File: rtl/pattern_seq_ctrl.sv
// Sequencer for one pattern_gen instance: seeds it, then streams its words over
// valid/ready, advancing the generator only on accepted beats.
module pattern_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 32,
  parameter int THR_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [LEN_W-1:0] length,
  input  logic [THR_W-1:0] throttle,
  input  logic             abort,
  output logic             gen_reset,
  output logic             gen_enable,
  output logic [2:0]       gen_mode,
  input  logic [WIDTH-1:0] gen_dout,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [LEN_W-1:0] word_count
);

  // state | meaning
  // IDLE  | waiting for start; word_count holds last run's total
  // SEED  | pattern_gen held in reset for one cycle with the latched mode
  // RUN   | out_valid high; each accepted beat advances the generator
  // GAP   | throttle idle cycles after an accepted beat
  // FIN   | one-cycle done pulse
  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_RUN,
    S_GAP,
    S_FIN
  } state_t;

  state_t             state, state_nxt;
  logic [2:0]         mode_q;
  logic [LEN_W-1:0]   len_q;
  logic [THR_W-1:0]   thr_q;
  logic [THR_W-1:0]   gap_cnt;
  logic [LEN_W-1:0]   word_cnt;
  logic               aborted_q;

  logic               beat;
  logic               abort_hit;
  logic               load_gap;
  logic               seed_st;
  logic               take_start;

  assign take_start = (state == S_IDLE) && start;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      mode_q    <= '0;
      len_q     <= '0;
      thr_q     <= '0;
      gap_cnt   <= '0;
      word_cnt  <= '0;
      aborted_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      aborted_q <= abort_hit;
      if (take_start) begin
        mode_q   <= mode;
        len_q    <= length;
        thr_q    <= throttle;
        word_cnt <= '0;
      end else if (beat) begin
        word_cnt <= word_cnt + LEN_W'(1);
      end
      // gap timer is a down-counter; terminal count 0 returns to RUN
      if (load_gap) begin
        gap_cnt <= thr_q - THR_W'(1);
      end else if (state == S_GAP) begin
        gap_cnt <= gap_cnt - THR_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    out_valid  = 1'b0;
    gen_enable = 1'b0;
    done       = 1'b0;
    beat       = 1'b0;
    abort_hit  = 1'b0;
    load_gap   = 1'b0;
    seed_st    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (length == '0) ? S_FIN : S_SEED;
        end
      end
      S_SEED: begin
        seed_st   = 1'b1;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        out_valid  = 1'b1;
        beat       = out_ready;
        gen_enable = out_ready;
        if (out_ready) begin
          if ((word_cnt + LEN_W'(1)) == len_q) begin
            state_nxt = S_FIN;
          end else if (thr_q != '0) begin
            state_nxt = S_GAP;
            load_gap  = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) begin
          state_nxt = S_RUN;
        end
      end
      S_FIN: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // abort overrides any transition, but a coincident beat has already counted
    if (abort && (state == S_SEED || state == S_RUN || state == S_GAP)) begin
      abort_hit = 1'b1;
      load_gap  = 1'b0;
      state_nxt = S_IDLE;
    end
  end

  assign gen_reset  = reset | seed_st;
  assign gen_mode   = mode_q;
  assign out_data   = gen_dout;
  assign busy       = (state != S_IDLE);
  assign aborted    = aborted_q;
  assign word_count = word_cnt;

endmodule

// File: tb/tb_pattern_seq_ctrl.sv
// Randomized bench for pattern_seq_ctrl with a behavioural pattern_gen stand-in
// and a run-level scoreboard.
module tb_pattern_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  mode = '0;
  logic [31:0] length = '0;
  logic [3:0]  throttle = '0;
  logic        abort = 1'b0;
  logic        gen_reset, gen_enable;
  logic [2:0]  gen_mode;
  logic [31:0] gen_dout = '0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy, done, aborted;
  logic [31:0] word_count;

  int n_total = 0;
  int n_bad = 0;

  pattern_seq_ctrl #(.WIDTH(32), .LEN_W(32), .THR_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .length(length),
    .throttle(throttle), .abort(abort), .gen_reset(gen_reset),
    .gen_enable(gen_enable), .gen_mode(gen_mode), .gen_dout(gen_dout),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .aborted(aborted), .word_count(word_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pg_seed(input int md);
    return (md == 1) ? 32'h0403_0201 : 32'h1;
  endfunction

  function automatic logic [31:0] pg_step(input int md, input logic [31:0] w);
    case (md)
      1:       return w[0] ? ((w >> 1) ^ 32'h8020_0003) : (w >> 1);
      2:       return {w[30:0], w[31]};
      default: return w + 32'd1;
    endcase
  endfunction

  function automatic logic [31:0] exp_word(input int md, input int k);
    logic [31:0] w = pg_seed(md);
    for (int i = 0; i < k; i++) w = pg_step(md, w);
    return w;
  endfunction

  always @(posedge clk) begin
    if (gen_reset) gen_dout <= pg_seed(int'(gen_mode));
    else if (gen_enable) gen_dout <= pg_step(int'(gen_mode), gen_dout);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // cycle 0 issues start; abort is raised on the first cycle where abort_at beats have been accepted
  task automatic do_run(input int md, input int len, input int thr, input int rdy_mode, input int abort_at);
    int k = 0, cyc = 1, first_valid = -1, gr_cnt = 0, done_cnt = 0, ab_cnt = 0;
    int idle_run = 0, last_beat_cyc = -10;
    bit after_beat = 0, prev_stall = 0, abort_sent = 0, finished = 0;
    logic [31:0] prev_data = '0;
    tick();
    start = 1'b1; mode = 3'(md); length = 32'(len); throttle = 4'(thr);
    abort = 1'b0; out_ready = 1'b1;
    #1;
    chk("idle_busy", busy, 0);
    while (!finished && cyc < 400) begin
      tick();
      start = abort_sent ? 1'b0 : 1'($urandom_range(0, 1));
      mode = 3'($urandom); length = $urandom; throttle = 4'($urandom);
      abort = (!abort_sent && abort_at >= 0 && k == abort_at);
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = (cyc % 3 == 2);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      #1;
      if (gen_reset) gr_cnt++;
      if (done) done_cnt++;
      if (aborted) ab_cnt++;
      chk("gen_enable", gen_enable, out_valid & out_ready);
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
      end
      if (out_valid && first_valid < 0) begin
        first_valid = cyc;
        chk("first_beat_lat", cyc, 2);
        chk("gen_mode", gen_mode, md);
      end
      if (out_valid && after_beat) begin
        chk("gap_len", idle_run, thr);
        after_beat = 0;
      end else if (!out_valid && after_beat) begin
        idle_run++;
      end
      if (out_valid && out_ready) begin
        chk("data", out_data, exp_word(md, k));
        k++;
        last_beat_cyc = cyc;
        after_beat = 1;
        idle_run = 0;
      end
      if (abort_sent) begin
        chk("abort_busy", busy, 0);
        chk("abort_pulse", aborted, 1);
        chk("abort_valid", out_valid, 0);
        finished = 1;
      end else if (done) begin
        chk("done_timing", cyc, (len == 0) ? 1 : last_beat_cyc + 1);
        chk("done_beats", k, len);
        finished = 1;
      end
      if (abort) abort_sent = 1;
      prev_stall = out_valid && !out_ready && !abort;
      prev_data = out_data;
      cyc++;
    end
    if (!finished) chk("run_timeout", 0, 1);
    tick();
    start = 1'b0; abort = 1'b0;
    #1;
    chk("end_busy", busy, 0);
    chk("word_count", word_count, (abort_at >= 0) ? k : len);
    chk("no_extra_pulse", {done, aborted}, 0);
    chk("done_pulses", done_cnt, (abort_at >= 0) ? 0 : 1);
    chk("abort_pulses", ab_cnt, (abort_at >= 0) ? 1 : 0);
    chk("gen_reset_cycles", gr_cnt, (len == 0) ? 0 : 1);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) tick();
    #1;
    chk("rst_gen_reset", gen_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_enable", gen_enable, 0);
    chk("rst_pulses", {done, aborted}, 0);
    chk("rst_word_count", word_count, 0);
    chk("rst_gen_mode", gen_mode, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_gen_reset", gen_reset, 0);

    do_run(0, 4, 0, 0, -1);
    do_run(2, 3, 2, 0, -1);
    do_run(1, 5, 0, 1, -1);
    do_run(0, 0, 0, 0, -1);
    do_run(3, 10, 1, 0, 3);
    do_run(3, 4, 0, 0, -1);
    do_run(1, 4, 0, 0, 3);
    do_run(2, 5, 0, 0, 0);

    // reset while streaming
    tick();
    start = 1'b1; mode = 3'd0; length = 32'd10; throttle = 4'd0; out_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_word_count", word_count, 0);
    chk("midrst_pulses", {done, aborted}, 0);
    tick();
    chk("midrst_pulses2", {done, aborted}, 0);

    for (int r = 0; r < 30; r++) begin
      int len, ab;
      len = $urandom_range(0, 12);
      ab = -1;
      if (len > 0 && $urandom_range(0, 3) == 0) ab = $urandom_range(0, len - 1);
      do_run($urandom_range(0, 7), len, $urandom_range(0, 3), $urandom_range(0, 2), ab);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
